// File: rtl/timer_apb_regif.sv
`default_nettype none
// ============================================================================
// Module  : timer_apb_regif
// Brief   : APB-style register interface for the timer (TDR/TCR/TSR/TCNT).
//           Optional macro TIMER_APB_SLVERR_EN enables pslverr responses.
// Revision: 1.0 - initial release
// ============================================================================
module timer_apb_regif #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [DATA_W-1:0] cnt_val,
    input  logic              ovf_set,
    input  logic              udf_set,
    output logic [DATA_W-1:0] tdr,
    output logic [DATA_W-1:0] tcr,
    output logic [1:0]        tsr
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    localparam int c_WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WAIT_INIT = c_WCNT_W'(WAIT_CYCLES);

    localparam logic [ADDR_W-1:0] c_ADDR_TDR  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_TCR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_TSR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_TCNT = ADDR_W'(3);
    localparam logic [DATA_W-1:0] c_TCR_MASK  = DATA_W'(8'hB3);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_tdr;
    logic [DATA_W-1:0]   r_tcr;
    logic [1:0]          r_tsr;

    logic                w_ready;
    logic                w_capture;
    logic                w_hit_tdr;
    logic                w_hit_tcr;
    logic                w_hit_tsr;
    logic                w_hit_tcnt;
    logic                w_mapped;
    logic                w_err;
    logic                w_commit;
    logic [1:0]          w_tsr_clr;
    logic [DATA_W-1:0]   w_rd_mux;

    // pready comes straight from flops so it never depends on bus inputs
    assign w_ready   = (r_state == c_ST_ACCESS) && (r_wait_cnt == '0);
    assign w_capture = psel && !penable && ((r_state == c_ST_IDLE) || w_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (psel && !penable) w_state_nxt = c_ST_SETUP;
            end
            c_ST_SETUP: begin
                w_state_nxt = psel ? c_ST_ACCESS : c_ST_IDLE;
            end
            c_ST_ACCESS: begin
                if (w_ready)     w_state_nxt = (psel && !penable) ? c_ST_SETUP : c_ST_IDLE;
                else if (!psel)  w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_addr     <= paddr;
                r_write    <= pwrite;
                r_wdata    <= pwdata;
                r_wait_cnt <= c_WAIT_INIT;
            end else if ((r_state == c_ST_ACCESS) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
        end
    end

    assign w_hit_tdr  = (r_addr == c_ADDR_TDR);
    assign w_hit_tcr  = (r_addr == c_ADDR_TCR);
    assign w_hit_tsr  = (r_addr == c_ADDR_TSR);
    assign w_hit_tcnt = (r_addr == c_ADDR_TCNT);
    assign w_mapped   = w_hit_tdr || w_hit_tcr || w_hit_tsr || w_hit_tcnt;

`ifdef TIMER_APB_SLVERR_EN
    assign w_err = !w_mapped || (r_write && w_hit_tcnt);
`else
    assign w_err = 1'b0;
`endif

    // Unmapped and TCNT writes never reach a register, error response or not
    assign w_commit  = w_ready && r_write && !w_err && w_mapped;
    assign w_tsr_clr = (w_commit && w_hit_tsr) ? r_wdata[1:0] : 2'b00;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_tdr <= '0;
            r_tcr <= '0;
            r_tsr <= 2'b00;
        end else begin
            if (w_commit && w_hit_tdr) r_tdr <= r_wdata;
            if (w_commit && w_hit_tcr) r_tcr <= r_wdata & c_TCR_MASK;
            r_tsr <= (r_tsr & ~w_tsr_clr) | {udf_set, ovf_set};
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_tdr)       w_rd_mux = r_tdr;
        else if (w_hit_tcr)  w_rd_mux = r_tcr;
        else if (w_hit_tsr)  w_rd_mux = {{(DATA_W-2){1'b0}}, r_tsr};
        else if (w_hit_tcnt) w_rd_mux = cnt_val;
    end

    assign prdata  = (w_ready && !w_err) ? w_rd_mux : '0;
    assign pready  = w_ready;
    assign pslverr = w_ready && w_err;
    assign tdr     = r_tdr;
    assign tcr     = r_tcr;
    assign tsr     = r_tsr;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_regif.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_apb_regif
// Brief   : Randomized self-checking bench for timer_apb_regif; index 0 is a
//           WAIT_CYCLES=1 instance, index 1 a zero-wait instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_apb_regif;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       psel[2];
    logic       penable[2];
    logic       pwrite[2];
    logic [7:0] paddr[2];
    logic [7:0] pwdata[2];
    logic [7:0] prdata[2];
    logic       pready[2];
    logic       pslverr[2];
    logic       ovf_set[2];
    logic       udf_set[2];
    logic [7:0] tdr[2];
    logic [7:0] tcr[2];
    logic [1:0] tsr[2];
    logic [7:0] cnt_val = 8'h00;

    logic [7:0] m_tdr[2];
    logic [7:0] m_tcr[2];
    logic [1:0] m_tsr[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    timer_apb_regif #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_dut_w1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .cnt_val(cnt_val),
        .ovf_set(ovf_set[0]), .udf_set(udf_set[0]),
        .tdr(tdr[0]), .tcr(tcr[0]), .tsr(tsr[0])
    );

    timer_apb_regif #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .cnt_val(cnt_val),
        .ovf_set(ovf_set[1]), .udf_set(udf_set[1]),
        .tdr(tdr[1]), .tcr(tcr[1]), .tsr(tsr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register file semantics from the address map
    function automatic logic model_err(input logic wr, input logic [7:0] addr);
`ifdef TIMER_APB_SLVERR_EN
        return (addr > 8'd3) || (wr && addr == 8'd3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic [7:0] addr);
        case (addr)
            8'd0:    return m_tdr[d];
            8'd1:    return m_tcr[d];
            8'd2:    return {6'd0, m_tsr[d]};
            8'd3:    return cnt_val;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_tdr[d] = 8'h00; m_tcr[d] = 8'h00; m_tsr[d] = 2'b00;
        end
    endtask

    task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic ovf_at_commit,
                        output logic [7:0] rdata, output logic err);
        int lat;
        @(negedge sys_clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        @(negedge sys_clk);
        penable[d] = 1'b1;
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!pready[d] && lat < 20);
        check($sformatf("latency[%0d]", d), lat, (d == 0) ? 2 : 1);
        rdata = prdata[d];
        err   = pslverr[d];
        if (ovf_at_commit) ovf_set[d] = 1'b1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (ovf_at_commit) begin
            @(negedge sys_clk);
            ovf_set[d] = 1'b0;
        end
    endtask

    task automatic do_op(input int d, input logic wr, input logic [7:0] addr,
                         input logic [7:0] data, input logic ovf_at_commit);
        logic [7:0] rd, exp_rd;
        logic       er, exp_er;
        exp_er = model_err(wr, addr);
        exp_rd = model_read(d, addr);
        xfer(d, wr, addr, data, ovf_at_commit, rd, er);
        check($sformatf("pslverr[%0d] a=%02h w=%0d", d, addr, wr), er, exp_er);
        if (!wr) check($sformatf("prdata[%0d] a=%02h", d, addr), rd, exp_rd);
        if (wr) begin
            case (addr)
                8'd0: m_tdr[d] = data;
                8'd1: m_tcr[d] = data & 8'hB3;
                8'd2: m_tsr[d] = m_tsr[d] & ~data[1:0];
                default: ;
            endcase
        end
        if (ovf_at_commit) m_tsr[d][0] = 1'b1;
    endtask

    task automatic check_regs(input int d);
        @(negedge sys_clk);
        check($sformatf("tdr[%0d]", d), tdr[d], m_tdr[d]);
        check($sformatf("tcr[%0d]", d), tcr[d], m_tcr[d]);
        check($sformatf("tsr[%0d]", d), tsr[d], m_tsr[d]);
    endtask

    task automatic pulse(input int d, input logic [1:0] flags);
        @(negedge sys_clk);
        ovf_set[d] = flags[0]; udf_set[d] = flags[1];
        @(negedge sys_clk);
        ovf_set[d] = 1'b0; udf_set[d] = 1'b0;
        m_tsr[d] = m_tsr[d] | {flags[1], flags[0]};
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00; ovf_set[d] = 1'b0; udf_set[d] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst pready[%0d]", d), pready[d], 1'b0);
            check($sformatf("rst pslverr[%0d]", d), pslverr[d], 1'b0);
            check($sformatf("rst prdata[%0d]", d), prdata[d], 8'h00);
            check($sformatf("rst tdr[%0d]", d), tdr[d], 8'h00);
            check($sformatf("rst tcr[%0d]", d), tcr[d], 8'h00);
            check($sformatf("rst tsr[%0d]", d), tsr[d], 2'b00);
        end
        sys_rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 3; a++) do_op(d, 1'b0, 8'(a), 8'h00, 1'b0);
            do_op(d, 1'b1, 8'h00, 8'hA5, 1'b0);
            do_op(d, 1'b0, 8'h00, 8'h00, 1'b0);
        end

        do_op(0, 1'b1, 8'hFE, 8'h5A, 1'b0);
        do_op(0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            do_op(0, 1'b1, 8'(8'hFF - i), 8'($urandom), 1'b0);
            do_op(0, 1'b0, 8'(8'hFF - i), 8'h00, 1'b0);
        end
        do_op(0, 1'b0, 8'h00, 8'h00, 1'b0);

        do_op(0, 1'b1, 8'h01, 8'hFF, 1'b0);
        do_op(0, 1'b0, 8'h01, 8'h00, 1'b0);
        cnt_val = 8'h3C;
        do_op(0, 1'b1, 8'h03, 8'h12, 1'b0);
        do_op(0, 1'b0, 8'h03, 8'h00, 1'b0);
        check_regs(0);

        pulse(0, 2'b01);
        check_regs(0);
        do_op(0, 1'b1, 8'h02, 8'h01, 1'b1);
        check_regs(0);
        do_op(0, 1'b1, 8'h02, 8'h01, 1'b0);
        check_regs(0);
        pulse(1, 2'b11);
        do_op(1, 1'b1, 8'h02, 8'h00, 1'b0);
        do_op(1, 1'b0, 8'h02, 8'h00, 1'b0);
        do_op(1, 1'b1, 8'h02, 8'h02, 1'b0);
        check_regs(1);

        // Reset while the write is still waiting in ACCESS
        @(negedge sys_clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h00; pwdata[0] = 8'h77;
        @(negedge sys_clk);
        penable[0] = 1'b1;
        @(negedge sys_clk);
        check("mid pready", pready[0], 1'b0);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("rst-mid pready", pready[0], 1'b0);
        sys_rst_n = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge sys_clk);
            check("post-rst pready", pready[0], 1'b0);
        end
        check_regs(0);
        check_regs(1);

        // Abandoned transfers must not commit
        do_op(0, 1'b1, 8'h00, 8'h11, 1'b0);
        do_op(1, 1'b1, 8'h00, 8'h22, 1'b0);
        @(negedge sys_clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; pwdata[0] = 8'h99;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'h99;
        @(negedge sys_clk);
        penable[0] = 1'b1;
        psel[1] = 1'b0;
        @(negedge sys_clk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            check("drop pready[0]", pready[0], 1'b0);
            check("drop pready[1]", pready[1], 1'b0);
        end
        check_regs(0);
        check_regs(1);

        for (int n = 0; n < 300; n++) begin
            int d;
            logic [7:0] a;
            d = int'($urandom_range(0, 1));
            cnt_val = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                pulse(d, 2'($urandom_range(1, 3)));
            end else begin
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                do_op(d, 1'($urandom), a, 8'($urandom), $urandom_range(0, 5) == 0);
            end
            if (n % 4 == 3) check_regs(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
